// File: rtl/tx_packet_arbiter.sv
// tx_packet_arbiter: shares one packet transmitter between two sources.
// Each source has a one-entry holding buffer. One tx_packet_wr pulse is
// issued per packet, and no new grant is made until tx_busy completes.
module tx_packet_arbiter #(
  parameter int unsigned DATA_BYTES = 16,
  parameter bit          FIXED_PRIO = 1'b0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req0_wr,
  input  logic [7:0]              req0_len,
  input  logic [8*DATA_BYTES-1:0] req0_data,
  output logic                    req0_busy,
  output logic                    req0_overflow,
  input  logic                    req1_wr,
  input  logic [7:0]              req1_len,
  input  logic [8*DATA_BYTES-1:0] req1_data,
  output logic                    req1_busy,
  output logic                    req1_overflow,
  input  logic                    tx_busy,
  output logic                    tx_packet_wr,
  output logic [7:0]              tx_payload_len,
  output logic [8*DATA_BYTES-1:0] tx_data,
  output logic                    tx_src
);

  localparam int unsigned DW = 8 * DATA_BYTES;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DELAY = 2'd1;
  localparam logic [1:0] S_BUSY  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          rr_q, rr_d;
  logic [1:0]    full_q, full_d;
  logic [1:0]    ovf_q, ovf_d;
  logic [7:0]    len0_q, len0_d, len1_q, len1_d;
  logic [DW-1:0] data0_q, data0_d, data1_q, data1_d;
  logic          txwr_q, txwr_d;
  logic [7:0]    txlen_q, txlen_d;
  logic [DW-1:0] txdata_q, txdata_d;
  logic          txsrc_q, txsrc_d;
  logic          gnt;

  // Next state: holder capture/overflow, then arbitration and issue.
  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    full_d   = full_q;
    ovf_d    = ovf_q;
    len0_d   = len0_q;
    len1_d   = len1_q;
    data0_d  = data0_q;
    data1_d  = data1_q;
    txwr_d   = 1'b0;
    txlen_d  = 8'd0;
    txdata_d = '0;
    txsrc_d  = 1'b0;
    gnt      = 1'b0;

    // A write into a full holder is dropped, even in the cycle it is issued.
    if (req0_wr) begin
      if (full_q[0]) begin
        ovf_d[0] = 1'b1;
      end else begin
        full_d[0] = 1'b1;
        len0_d    = req0_len;
        data0_d   = req0_data;
      end
    end
    if (req1_wr) begin
      if (full_q[1]) begin
        ovf_d[1] = 1'b1;
      end else begin
        full_d[1] = 1'b1;
        len1_d    = req1_len;
        data1_d   = req1_data;
      end
    end

    case (state_q)
      S_IDLE: begin
        if ((|full_q) && !tx_busy) begin
          if (&full_q) begin
            gnt = FIXED_PRIO ? 1'b0 : rr_q;
          end else begin
            gnt = ~full_q[0];
          end
          txwr_d      = 1'b1;
          txlen_d     = gnt ? len1_q : len0_q;
          txdata_d    = gnt ? data1_q : data0_q;
          txsrc_d     = gnt;
          full_d[gnt] = 1'b0;
          rr_d        = ~gnt;
          state_d     = S_DELAY;
        end
      end
      S_DELAY: state_d = S_BUSY;
      S_BUSY: begin
        if (!tx_busy) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, holder and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      rr_q     <= 1'b0;
      full_q   <= 2'b00;
      ovf_q    <= 2'b00;
      len0_q   <= 8'd0;
      len1_q   <= 8'd0;
      data0_q  <= '0;
      data1_q  <= '0;
      txwr_q   <= 1'b0;
      txlen_q  <= 8'd0;
      txdata_q <= '0;
      txsrc_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      rr_q     <= rr_d;
      full_q   <= full_d;
      ovf_q    <= ovf_d;
      len0_q   <= len0_d;
      len1_q   <= len1_d;
      data0_q  <= data0_d;
      data1_q  <= data1_d;
      txwr_q   <= txwr_d;
      txlen_q  <= txlen_d;
      txdata_q <= txdata_d;
      txsrc_q  <= txsrc_d;
    end
  end

  assign req0_busy      = full_q[0];
  assign req1_busy      = full_q[1];
  assign req0_overflow  = ovf_q[0];
  assign req1_overflow  = ovf_q[1];
  assign tx_packet_wr   = txwr_q;
  assign tx_payload_len = txlen_q;
  assign tx_data        = txdata_q;
  assign tx_src         = txsrc_q;

endmodule

// File: tb/tb_tx_packet_arbiter.sv
// Bench for tx_packet_arbiter: a round-robin and a fixed-priority instance
// share stimulus; a packet-level reference model predicts both.
module tb_tx_packet_arbiter;

  localparam int unsigned DB = 16;
  localparam int unsigned DW = 8 * DB;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0_wr = 1'b0, req1_wr = 1'b0, tx_busy = 1'b0;
  logic [7:0]    req0_len = 8'd0, req1_len = 8'd0;
  logic [DW-1:0] req0_data = '0, req1_data = '0;

  logic [1:0]    o_wr, o_src, o_b0, o_b1, o_f0, o_f1;
  logic [7:0]    o_len  [2];
  logic [DW-1:0] o_data [2];

  int checks = 0;
  int errors = 0;

  // Reference model state, index [cfg][src]; cfg 0 = round-robin, 1 = fixed.
  bit            m_v   [2][2];
  bit            m_ovf [2][2];
  logic [7:0]    m_len [2][2];
  logic [DW-1:0] m_data[2][2];
  bit            m_idle[2];
  int            m_since[2];
  bit            m_rr  [2];
  bit            e_wr  [2];
  bit            e_src [2];
  logic [7:0]    e_len [2];
  logic [DW-1:0] e_data[2];

  always #5 clk = ~clk;

  tx_packet_arbiter #(.DATA_BYTES(DB), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .rst(rst),
    .req0_wr(req0_wr), .req0_len(req0_len), .req0_data(req0_data),
    .req0_busy(o_b0[0]), .req0_overflow(o_f0[0]),
    .req1_wr(req1_wr), .req1_len(req1_len), .req1_data(req1_data),
    .req1_busy(o_b1[0]), .req1_overflow(o_f1[0]),
    .tx_busy(tx_busy), .tx_packet_wr(o_wr[0]), .tx_payload_len(o_len[0]),
    .tx_data(o_data[0]), .tx_src(o_src[0])
  );

  tx_packet_arbiter #(.DATA_BYTES(DB), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .rst(rst),
    .req0_wr(req0_wr), .req0_len(req0_len), .req0_data(req0_data),
    .req0_busy(o_b0[1]), .req0_overflow(o_f0[1]),
    .req1_wr(req1_wr), .req1_len(req1_len), .req1_data(req1_data),
    .req1_busy(o_b1[1]), .req1_overflow(o_f1[1]),
    .tx_busy(tx_busy), .tx_packet_wr(o_wr[1]), .tx_payload_len(o_len[1]),
    .tx_data(o_data[1]), .tx_src(o_src[1])
  );

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < int'(DB); i++) d[i*8 +: 8] = 8'($urandom);
    return d;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      for (int s = 0; s < 2; s++) begin
        m_v[c][s] = 0; m_ovf[c][s] = 0; m_len[c][s] = '0; m_data[c][s] = '0;
      end
      m_idle[c] = 1; m_since[c] = 0; m_rr[c] = 0;
      e_wr[c] = 0; e_src[c] = 0; e_len[c] = '0; e_data[c] = '0;
    end
  endtask

  // One clock edge of the packet-level model for configuration c.
  task automatic model_edge(input int c);
    bit         wr_s [2];
    bit         grant;
    int         g;
    wr_s[0] = req0_wr; wr_s[1] = req1_wr;
    grant = 0; g = 0;
    if (m_idle[c]) begin
      if (!tx_busy && (m_v[c][0] || m_v[c][1])) begin
        grant = 1;
        if (m_v[c][0] && m_v[c][1]) g = (c == 1) ? 0 : int'(m_rr[c]);
        else                        g = m_v[c][0] ? 0 : 1;
      end
    end else begin
      m_since[c]++;
      if (m_since[c] >= 2 && !tx_busy) m_idle[c] = 1;
    end
    e_wr[c]   = grant;
    e_src[c]  = grant ? (g == 1) : 1'b0;
    e_len[c]  = grant ? m_len[c][g]  : 8'd0;
    e_data[c] = grant ? m_data[c][g] : '0;
    for (int s = 0; s < 2; s++) begin
      if (wr_s[s]) begin
        if (m_v[c][s]) m_ovf[c][s] = 1;
        else begin
          m_v[c][s]    = 1;
          m_len[c][s]  = s ? req1_len  : req0_len;
          m_data[c][s] = s ? req1_data : req0_data;
        end
      end
    end
    if (grant) begin
      m_v[c][g] = 0; m_rr[c] = (g == 0); m_idle[c] = 0; m_since[c] = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (!rst) for (int c = 0; c < 2; c++) model_edge(c);
    #1;
  endtask

  task automatic do_reset();
    rst = 1; req0_wr = 0; req1_wr = 0; tx_busy = 0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic wait_pulse(output bit ok);
    ok = 0;
    for (int n = 0; n < 40; n++) begin
      tick();
      if (o_wr[0] || o_wr[1]) begin ok = 1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1; #1;
    for (int c = 0; c < 2; c++) begin
      checks++;
      if ({o_wr[c], o_src[c], o_b0[c], o_b1[c], o_f0[c], o_f1[c]} !== 6'b0 ||
          o_len[c] !== 8'd0 || o_data[c] !== '0) begin
        errors++;
        $display("FAIL reset c%0d wr=%b src=%b b=%b%b f=%b%b len=%h expected all 0",
                 c, o_wr[c], o_src[c], o_b0[c], o_b1[c], o_f0[c], o_f1[c], o_len[c]);
      end
    end
    do_reset();
  endtask

  task automatic test_single();
    int pulses;
    do_reset();
    req0_wr = 1; req0_len = 8'd1; req0_data = '0; req0_data[7:0] = 8'h81;
    tick(); req0_wr = 0;
    checks++;
    if (o_b0[0] !== 1'b1 || o_wr[0] !== 1'b0) begin
      errors++; $display("FAIL single_hold busy=%b wr=%b expected busy=1 wr=0", o_b0[0], o_wr[0]);
    end
    tick();
    checks++;
    if (o_wr[0] !== 1'b1 || o_len[0] !== 8'd1 || o_data[0][7:0] !== 8'h81 ||
        o_src[0] !== 1'b0 || o_b0[0] !== 1'b0) begin
      errors++;
      $display("FAIL single_issue wr=%b len=%h b0=%h src=%b busy=%b expected 1 01 81 0 0",
               o_wr[0], o_len[0], o_data[0][7:0], o_src[0], o_b0[0]);
    end
    pulses = 0;
    repeat (8) begin tick(); if (o_wr[0]) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL single_extra pulses=%0d expected 0", pulses); end
  endtask

  task automatic test_rr_pair();
    bit ok;
    logic [DW-1:0] d0, d1, d2;
    do_reset();
    d0 = rand_data(); d1 = rand_data(); d2 = rand_data();
    req0_wr = 1; req0_len = 8'd3; req0_data = d0;
    req1_wr = 1; req1_len = 8'd4; req1_data = d1;
    tick(); req0_wr = 0; req1_wr = 0;
    tick();
    checks++;
    if (o_wr !== 2'b11 || o_src !== 2'b00 || o_data[0] !== d0) begin
      errors++; $display("FAIL rr_first wr=%b src=%b expected wr=11 src=00", o_wr, o_src);
    end
    // Refill req0 while req1 still waits: round-robin now favours req1.
    tx_busy = 1; req0_wr = 1; req0_len = 8'd5; req0_data = d2;
    tick(); req0_wr = 0;
    repeat (2) tick();
    tx_busy = 0;
    wait_pulse(ok);
    checks++;
    if (!ok || o_wr !== 2'b11 || o_src[0] !== 1'b1 || o_len[0] !== 8'd4 || o_data[0] !== d1 ||
        o_src[1] !== 1'b0 || o_len[1] !== 8'd5) begin
      errors++;
      $display("FAIL rr_second ok=%b wr=%b src=%b len=%h/%h expected 1 11 rr=1 fp=0 len 04/05",
               ok, o_wr, o_src, o_len[0], o_len[1]);
    end
    wait_pulse(ok);
    checks++;
    if (!ok || o_src[0] !== 1'b0 || o_len[0] !== 8'd5 || o_src[1] !== 1'b1 || o_data[1] !== d1) begin
      errors++;
      $display("FAIL rr_third ok=%b src=%b len=%h expected rr src0 len 05, fp src1",
               ok, o_src, o_len[0]);
    end
  endtask

  task automatic test_fixed_prio();
    int fp0;
    do_reset();
    fp0 = 0;
    repeat (60) begin
      req0_wr = !m_v[1][0]; req0_len = 8'($urandom); req0_data = rand_data();
      req1_wr = !m_v[1][1]; req1_len = 8'($urandom); req1_data = rand_data();
      tick();
      if (o_wr[1]) begin
        checks++; fp0++;
        if (o_src[1] !== 1'b0) begin
          errors++; $display("FAIL fixed_src src=%b expected 0", o_src[1]);
        end
      end
      checks++;
      if (o_wr[0] !== e_wr[0] || o_src[0] !== e_src[0] || o_len[0] !== e_len[0]) begin
        errors++;
        $display("FAIL fixed_rr wr=%b src=%b len=%h expected %b %b %h",
                 o_wr[0], o_src[0], o_len[0], e_wr[0], e_src[0], e_len[0]);
      end
    end
    req0_wr = 0; req1_wr = 0;
    checks++;
    if (fp0 < 10 || o_f0[1] !== 1'b0) begin
      errors++; $display("FAIL fixed_count grants=%0d ovf=%b expected >=10 and 0", fp0, o_f0[1]);
    end
  endtask

  task automatic test_overflow();
    bit ok;
    logic [DW-1:0] da, db;
    do_reset();
    da = rand_data(); db = rand_data();
    tx_busy = 1;
    req1_wr = 1; req1_len = 8'd7; req1_data = da;
    tick();
    req1_len = 8'd9; req1_data = db;
    tick(); req1_wr = 0;
    checks++;
    if (o_f1[0] !== 1'b1 || o_b1[0] !== 1'b1 || o_f0[0] !== 1'b0 || o_wr[0] !== 1'b0) begin
      errors++;
      $display("FAIL ovf_set f1=%b b1=%b f0=%b wr=%b expected 1 1 0 0", o_f1[0], o_b1[0], o_f0[0], o_wr[0]);
    end
    tx_busy = 0;
    wait_pulse(ok);
    checks++;
    if (!ok || o_src[0] !== 1'b1 || o_len[0] !== 8'd7 || o_data[0] !== da) begin
      errors++; $display("FAIL ovf_data ok=%b src=%b len=%h expected 1 1 07", ok, o_src[0], o_len[0]);
    end
    repeat (5) tick();
    checks++;
    if (o_f1[0] !== 1'b1 || o_b1[0] !== 1'b0) begin
      errors++; $display("FAIL ovf_sticky f1=%b b1=%b expected 1 0", o_f1[0], o_b1[0]);
    end
  endtask

  task automatic test_long_busy();
    int bad;
    do_reset();
    req0_wr = 1; req0_len = 8'd0; req0_data = rand_data();
    req1_wr = 1; req1_len = 8'd200; req1_data = rand_data();
    tick(); req0_wr = 0; req1_wr = 0;
    tick();
    checks++;
    if (o_wr[0] !== 1'b1 || o_len[0] !== 8'd0 || o_src[0] !== 1'b0) begin
      errors++; $display("FAIL busy_first wr=%b len=%h src=%b expected 1 00 0", o_wr[0], o_len[0], o_src[0]);
    end
    tx_busy = 1; bad = 0;
    repeat (20) begin
      tick();
      if (o_wr[0] || o_len[0] != 8'd0 || o_data[0] != '0 || o_src[0]) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL busy_quiet nonzero_cycles=%0d expected 0", bad); end
    tx_busy = 0;
    tick();
    checks++;
    if (o_wr[0] !== 1'b0) begin errors++; $display("FAIL busy_early wr=%b expected 0", o_wr[0]); end
    tick();
    checks++;
    if (o_wr[0] !== 1'b1 || o_src[0] !== 1'b1 || o_len[0] !== 8'd200) begin
      errors++; $display("FAIL busy_second wr=%b src=%b len=%h expected 1 1 c8", o_wr[0], o_src[0], o_len[0]);
    end
  endtask

  task automatic test_reset_mid();
    int pulses;
    do_reset();
    req0_wr = 1; req0_len = 8'd2; req0_data = rand_data();
    req1_wr = 1; req1_len = 8'd6; req1_data = rand_data();
    tick(); req0_wr = 0; req1_wr = 0;
    tick();
    tx_busy = 1;
    repeat (3) tick();
    checks++;
    if (o_b1[0] !== 1'b1) begin errors++; $display("FAIL mid_pre b1=%b expected 1", o_b1[0]); end
    #2 rst = 1;
    #1;
    checks++;
    if (o_wr[0] !== 1'b0 || o_b1[0] !== 1'b0 || o_b0[0] !== 1'b0 || o_len[0] !== 8'd0 ||
        o_data[0] !== '0 || o_src[0] !== 1'b0) begin
      errors++; $display("FAIL mid_rst wr=%b b1=%b len=%h expected 0 0 00", o_wr[0], o_b1[0], o_len[0]);
    end
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0; tx_busy = 0;
    pulses = 0;
    repeat (10) begin tick(); if (o_wr[0] || o_wr[1]) pulses++; end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL mid_after pulses=%0d expected 0", pulses); end
  endtask

  task automatic test_random();
    do_reset();
    repeat (400) begin
      req0_wr = ($urandom_range(0, 2) == 0); req0_len = 8'($urandom); req0_data = rand_data();
      req1_wr = ($urandom_range(0, 2) == 0); req1_len = 8'($urandom); req1_data = rand_data();
      tx_busy = ($urandom_range(0, 3) == 0);
      tick();
      for (int c = 0; c < 2; c++) begin
        checks++;
        if (o_wr[c] !== e_wr[c] || o_src[c] !== e_src[c] || o_len[c] !== e_len[c] ||
            o_data[c] !== e_data[c]) begin
          errors++;
          $display("FAIL rnd_tx c%0d t=%0t wr=%b src=%b len=%h data=%h expected %b %b %h %h",
                   c, $time, o_wr[c], o_src[c], o_len[c], o_data[c], e_wr[c], e_src[c], e_len[c], e_data[c]);
        end
        checks++;
        if (o_b0[c] !== m_v[c][0] || o_b1[c] !== m_v[c][1] ||
            o_f0[c] !== m_ovf[c][0] || o_f1[c] !== m_ovf[c][1]) begin
          errors++;
          $display("FAIL rnd_hold c%0d t=%0t busy=%b%b ovf=%b%b expected %b%b %b%b", c, $time,
                   o_b0[c], o_b1[c], o_f0[c], o_f1[c], m_v[c][0], m_v[c][1], m_ovf[c][0], m_ovf[c][1]);
        end
      end
    end
    req0_wr = 0; req1_wr = 0; tx_busy = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_rr_pair();
    test_fixed_prio();
    test_overflow();
    test_long_busy();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
